// File: rtl/tx_frame_sender_if.sv
// Frame-buffer read port, UART byte handshake and status flags of tx_frame_sender.
// The master side is the sender; the slave side is the buffer/UART/controller environment.
interface tx_frame_sender_if;
  logic       frame_done;
  logic       re;
  logic [7:0] rData;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       frame_sent;

  modport master (
    input  frame_done, rData, tx_ready,
    output re, tx_valid, tx_data, busy, frame_sent
  );

  modport slave (
    output frame_done, rData, tx_ready,
    input  re, tx_valid, tx_data, busy, frame_sent
  );
endinterface

// File: rtl/tx_frame_sender.sv
// Streams one frame as SOF marker, PIXELS buffer bytes and EOF marker over a
// valid/ready byte interface, fetching one pixel per FETCH/WAIT/SEND round.
module tx_frame_sender #(
  parameter int unsigned PIXELS   = 176 * 240,
  parameter logic [7:0]  SOF_BYTE = 8'hA5,
  parameter logic [7:0]  EOF_BYTE = 8'h5A
) (
  input  logic                clk,
  input  logic                reset,
  tx_frame_sender_if.master   bus
);

  localparam int unsigned CNT_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_EOF,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;
  logic [7:0]       tx_data_nxt;
  logic             re_nxt, tx_valid_nxt, busy_nxt, frame_sent_nxt;

  // State and pixel counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pix_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pix_cnt <= pix_cnt_nxt;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_nxt   = state;
    pix_cnt_nxt = pix_cnt;
    tx_data_nxt = bus.tx_data;
    case (state)
      ST_IDLE: begin
        if (bus.frame_done) begin
          state_nxt   = ST_SOF;
          pix_cnt_nxt = '0;
          tx_data_nxt = SOF_BYTE;
        end
      end
      ST_SOF: begin
        if (bus.tx_ready) state_nxt = ST_FETCH;
      end
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        state_nxt   = ST_SEND;
        tx_data_nxt = bus.rData;
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          if (pix_cnt == LAST_PIX) begin
            state_nxt   = ST_EOF;
            tx_data_nxt = EOF_BYTE;
          end else begin
            state_nxt   = ST_FETCH;
            pix_cnt_nxt = pix_cnt + CNT_W'(1);
          end
        end
      end
      ST_EOF: begin
        if (bus.tx_ready) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    re_nxt         = (state_nxt == ST_FETCH);
    tx_valid_nxt   = (state_nxt == ST_SOF) || (state_nxt == ST_SEND) || (state_nxt == ST_EOF);
    busy_nxt       = (state_nxt != ST_IDLE);
    frame_sent_nxt = (state_nxt == ST_DONE);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.re         <= 1'b0;
      bus.tx_valid   <= 1'b0;
      bus.tx_data    <= 8'h00;
      bus.busy       <= 1'b0;
      bus.frame_sent <= 1'b0;
    end else begin
      bus.re         <= re_nxt;
      bus.tx_valid   <= tx_valid_nxt;
      bus.tx_data    <= tx_data_nxt;
      bus.busy       <= busy_nxt;
      bus.frame_sent <= frame_sent_nxt;
    end
  end

endmodule

// File: doc/tx_frame_sender.md
TX_FRAME_SENDER -- requirements
Module: tx_frame_sender

Interface
REQ-001 SHALL have parameter PIXELS, default 176*240 (42240), meaning number of pixel bytes per frame.
REQ-002 SHALL have parameter SOF_BYTE, default 8'hA5, meaning start-of-frame marker byte.
REQ-003 SHALL have parameter EOF_BYTE, default 8'h5A, meaning end-of-frame marker byte.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_done  input  1  frame-buffer-ready flag from the edge frame buffer (level or single-cycle pulse).
REQ-007 SHALL have port re  output  1  read-advance strobe to the frame buffer; one pulse per pixel.
REQ-008 SHALL have port rData  input  8  frame buffer read data, valid the cycle after the re pulse.
REQ-009 SHALL have port tx_valid  output  1  byte available to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte to transmit.
REQ-011 SHALL have port tx_ready  input  1  UART transmitter can accept a byte; a byte transfers when tx_valid and tx_ready are both 1 on a clock edge.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-013 SHALL have port frame_sent  output  1  single-cycle pulse after the EOF byte is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, SOF, FETCH, WAIT, SEND, EOF, DONE, with busy = (state != IDLE).
REQ-015 SHALL, in IDLE with frame_done=1 at edge N, enter SOF at N+1 with tx_valid=1 and tx_data=SOF_BYTE; pix_cnt cleared to 0.
REQ-016 SHALL, in SOF, EOF and SEND, hold tx_valid=1 and tx_data stable until the edge where tx_ready=1; it shall never drop tx_valid or change tx_data before acceptance.
REQ-017 SHALL, on SOF acceptance, go to FETCH.
REQ-018 SHALL, in FETCH, assert re=1 for exactly one cycle, then go to WAIT; re SHALL be 0 in every other state.
REQ-019 SHALL, at the edge leaving WAIT, register tx_data<=rData and tx_valid<=1 and enter SEND.
REQ-020 SHALL, on SEND acceptance, go to EOF if pix_cnt==PIXELS-1, else increment pix_cnt and go to FETCH.
REQ-021 SHALL, on EOF acceptance (tx_data=EOF_BYTE), go to DONE, drop tx_valid, and assert frame_sent=1 for exactly the DONE cycle, then return to IDLE.
REQ-022 SHALL keep pix_cnt at $clog2(PIXELS) bits (16 bits at default) and never wrap within a frame.
REQ-023 SHALL ignore frame_done in every state except IDLE; no request is queued.
REQ-024 SHALL issue exactly PIXELS re pulses per frame, in addresses 0..PIXELS-1 order, and PIXELS+2 transferred bytes in total.
REQ-025 SHALL, with tx_ready held 1, sustain 3 cycles per pixel (FETCH, WAIT, SEND).
REQ-026 SHALL deassert tx_valid in IDLE, FETCH, WAIT and DONE.

Reset
REQ-027 SHALL, when reset=1 at an edge in any state including mid-frame, go to IDLE with re=0, tx_valid=0, tx_data=8'h00, busy=0, frame_sent=0, pix_cnt=0.
REQ-028 SHALL give reset priority over frame_done and tx_ready in the same cycle.
REQ-029 SHALL not resume an aborted frame after reset; the next frame starts only on a new frame_done in IDLE.

Verification
REQ-030 Bench SHALL run a PIXELS=4 frame with buffer bytes 11,22,33,44 and tx_ready=1 -> byte stream A5,11,22,33,44,5A, 4 re pulses, one frame_sent pulse, 14 cycles from frame_done to frame_sent.
REQ-031 Bench SHALL apply tx_ready backpressure (0 for 5 cycles while in SEND holding 22) -> tx_data stays 22, tx_valid stays 1, no extra re pulse, stream unchanged.
REQ-032 Bench SHALL run a default-size frame with random tx_ready -> exactly 42242 bytes, 42240 re pulses, pixel data matches buffer contents in order.
REQ-033 Bench SHALL assert reset during pixel 100 of a frame -> next cycle all outputs 0, busy=0; a following frame_done yields a full fresh frame starting with A5.
REQ-034 Bench SHALL pulse frame_done while busy -> ignored, exactly one frame sent; frame_done and reset asserted together in IDLE -> remains IDLE.
